// File: rtl/mem_mover_pkg.sv
// Shared types for the memory block mover: FSM state and operation encodings.
package mem_mover_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } mover_state_t;

  typedef enum logic {
    OP_COPY,
    OP_FILL
  } mover_op_t;

endpackage

// File: rtl/mem_block_mover.sv
// Memory block mover: bus initiator that copies (read src, write dst) or fills
// (write constant to dst) a block of bytes, one byte per access, with stalls
// whenever the core holds the memory port (mem_gnt low).
module mem_block_mover
  import mem_mover_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_value,
  output logic          busy,
  output logic          done,
  input  logic          mem_gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW:0] CNT_LAST = {{AW{1'b0}}, 1'b1};

  mover_state_t  state;
  mover_state_t  state_nxt;
  mover_op_t     op_q;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic [AW:0]   cnt;
  logic [DW-1:0] hold;
  logic [DW-1:0] fill_q;

  // State register; reset aborts any transfer in flight, so no done pulse follows.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: a transfer of len bytes walks RD/WR per byte, WR only for FILL.
  // NOTE: a default is assigned first so every path drives state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_nxt = DONE;
          end else if (mover_op_t'(op) == OP_FILL) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      RD: begin
        if (mem_gnt) begin
          state_nxt = WR;
        end
      end
      WR: begin
        if (mem_gnt) begin
          if (cnt == CNT_LAST) begin
            state_nxt = DONE;
          end else if (op_q == OP_FILL) begin
            state_nxt = WR;
          end else begin
            state_nxt = RD;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: latch parameters on start, capture read data, advance pointers after each write.
  // NOTE: the small pointer/count/hold registers are all cleared on reset so an aborted
  // transfer leaves no residue; there is no memory array in this block to reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_COPY;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      hold    <= '0;
      fill_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q    <= mover_op_t'(op);
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            cnt     <= len;
            fill_q  <= fill_value;
          end
        end
        RD: begin
          if (mem_gnt) begin
            hold <= mem_rdata;
          end
        end
        WR: begin
          if (mem_gnt) begin
            // Both pointers advance together and wrap naturally at 2^AW.
            src_ptr <= src_ptr + 1'b1;
            dst_ptr <= dst_ptr + 1'b1;
            cnt     <= cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory port and status decode: only granted RD/WR cycles touch memory; everything else is 0.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state == RD) || (state == WR);
    done      = (state == DONE);
    if (state == RD && mem_gnt) begin
      mem_read = 1'b1;
      mem_addr = src_ptr;
    end
    if (state == WR && mem_gnt) begin
      mem_write = 1'b1;
      mem_addr  = dst_ptr;
      mem_wdata = (op_q == OP_FILL) ? fill_q : hold;
    end
  end

endmodule
